des_round_seq: RTL and testbench
================================

Name: des_round_seq

Overview:
- Sequencer for the iterative 16-round DES core (roundSel / decrypt / key / desIn / desOut interface).
- Accepts one block plus key and direction over a valid/ready handshake.
- Holds key, direction and data stable while it steps roundSel 0..ROUNDS-1, then captures desOut into an output holding register and presents it with valid/ready.
- Sits between the requester logic and the DES core instance in top-level integrations.

Parameters:
ROUNDS, 16, core iterations per pass; roundSel counts 0..ROUNDS-1. Must be ≤16.
CNT_W, 16, width of completed-block counter.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (low = reset)
in_valid  in  1  request block present
in_ready  out  1  sequencer can accept block
in_decrypt  in  1  1 = decrypt, 0 = encrypt
in_key  in  56  DES key (parity stripped)
in_data  in  64  input block
out_valid  out  1  result held in out_data
out_ready  in  1  consumer takes result
out_data  out  64  result block
core_round_sel  out  4  to core roundSel
core_decrypt  out  1  to core decrypt
core_key  out  56  to core key
core_din  out  64  to core desIn
core_dout  in  64  from core desOut
busy  out  1  state != IDLE
blk_cnt  out  CNT_W  completed blocks, saturating

Behaviour:
- Core contract: core loads core_din in the cycle core_round_sel=0. It advances one round per clk. core_dout is valid in the cycle after core_round_sel=ROUNDS-1.
- FSM states: IDLE, RUN, CAPT, DONE.
- IDLE: in_ready=1. On an edge with in_valid&in_ready, latch in_key/in_decrypt/in_data into the key/dir/data registers, set round=0, go to RUN.
- RUN: core_round_sel=round. round increments each edge. At the edge where round=ROUNDS-1, go to CAPT and clear round to 0.
- CAPT: one cycle. At its edge, out_data<=core_dout, out_valid<=1, blk_cnt increments (saturates at all-ones), go to DONE.
- DONE: out_valid=1; out_data stays stable until out_valid&out_ready. On that edge, out_valid<=0 and go to IDLE. in_ready=0 in DONE (no overlap).
- Latency: accept edge A. core_round_sel=0 in cycle A+1 and ROUNDS-1 in cycle A+ROUNDS. out_valid is first high after edge A+ROUNDS+1 (17 cycles for the default).
- Minimum block period: ROUNDS+3 cycles when out_ready is tied high.
- core_key, core_decrypt and core_din are driven from the latched registers only. They are constant from accept until the next accept; in_* changes are ignored outside IDLE.
- core_round_sel = 0 in IDLE, CAPT and DONE.
- Reset values (rst low, async): state=IDLE, round=0, out_valid=0, out_data=0, blk_cnt=0, key/dir/data registers=0. Consequently in_ready=1 and busy=0 immediately after reset release.
- Reset asserted mid-RUN or in DONE: the block is discarded, no out_valid pulse, blk_cnt not incremented past its pre-reset value (it clears to 0).
- in_valid held high while busy: no effect. The request is taken on the first IDLE cycle.
- out_ready high in any state other than DONE: ignored.

Optional Feature:
- Macro: DES_ROUND_SEQ_TDES_EN.
- When defined:
  - Adds ports in_tdes (in, 1), in_key2 (in, 56), in_key3 (in, 56).
  - With in_tdes=1 the FSM performs three passes (RUN, CAPT) ×3. Each CAPT result is fed back as core_din for the next pass; only the third CAPT sets out_valid.
  - Encrypt (in_decrypt=0) is EDE: enc k1, dec k2, enc k3.
  - Decrypt (in_decrypt=1): dec k3, enc k2, dec k1.
  - TDES latency: 3·(ROUNDS+1) = 51 cycles from accept to out_valid.
  - blk_cnt increments once per TDES block.
  - in_tdes=0 behaves exactly as single DES.
- When undefined: the three ports are absent and single-DES behaviour only.

Test Plan:
- Reset then accept in_data=0x0123456789ABCDEF, in_key=0x0, in_decrypt=0 -> core_round_sel steps 0..15 over 16 consecutive cycles. out_valid rises 17 cycles after accept. out_data matches bench DES model. blk_cnt=1.
- Encrypt, then decrypt the captured result with the same key -> second out_data=0x0123456789ABCDEF. core_decrypt=1 for all 16 rounds of the second block.
- Hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored. On the out_ready pulse the handshake completes, and in_ready=1 on the next cycle.
- Assert rst low at round 7, release, submit a new block -> no out_valid for the aborted block. blk_cnt=0, then 1 after the new block; the new result is correct.
- Change in_key/in_data every cycle during RUN -> core_key/core_din hold the accepted values; the result is unaffected.
- With DES_ROUND_SEQ_TDES_EN and k1=k2=k3 -> out_data equals single-DES encrypt. Latency is 51 cycles and blk_cnt increments by 1.

Source files
------------

// File: rtl/des_round_seq.sv
// des_round_seq: sequencer driving an iterative DES core (roundSel/decrypt/key/desIn/desOut).
// Latency: accept edge A -> out_valid high after edge A+ROUNDS+1 (3*(ROUNDS+1) for triple-DES blocks).
// Backpressure: in_ready only in IDLE; result held in out_data until out_valid&out_ready.
// Optional: define DES_ROUND_SEQ_TDES_EN for three-pass triple-DES (EDE) support.
module des_round_seq #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [55:0]      in_key,
  input  logic [63:0]      in_data,
`ifdef DES_ROUND_SEQ_TDES_EN
  input  logic             in_tdes,
  input  logic [55:0]      in_key2,
  input  logic [55:0]      in_key3,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [3:0]       core_round_sel,
  output logic             core_decrypt,
  output logic [55:0]      core_key,
  output logic [63:0]      core_din,
  input  logic [63:0]      core_dout,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0]       LAST_RND = 4'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_round;
  logic [55:0]      r_key;
  logic             r_dir;
  logic [63:0]      r_data;
  logic             r_out_vld;
  logic [63:0]      r_out_data;
  logic [CNT_W-1:0] r_blk_cnt;
  logic             w_final_pass;
  logic [55:0]      w_core_key;
  logic             w_core_dec;

`ifdef DES_ROUND_SEQ_TDES_EN
  logic             r_tdes;
  logic [1:0]       r_pass;
  logic [55:0]      r_key2;
  logic [55:0]      r_key3;

  // Only the third pass of a triple-DES block produces the visible result.
  assign w_final_pass = !r_tdes || (r_pass == 2'd2);

  // Key/direction per pass: encrypt = E(k1) D(k2) E(k3); decrypt = D(k3) E(k2) D(k1).
  always_comb begin
    w_core_key = r_key;
    w_core_dec = r_dir;
    if (r_tdes) begin
      case (r_pass)
        2'd0: begin
          w_core_key = r_dir ? r_key3 : r_key;
          w_core_dec = r_dir;
        end
        2'd1: begin
          w_core_key = r_key2;
          w_core_dec = !r_dir;
        end
        default: begin
          w_core_key = r_dir ? r_key : r_key3;
          w_core_dec = r_dir;
        end
      endcase
    end
  end

  // Triple-DES mode, pass index and extra keys are latched with the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tdes <= 1'b0;
      r_pass <= 2'd0;
      r_key2 <= '0;
      r_key3 <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_tdes <= in_tdes;
      r_pass <= 2'd0;
      r_key2 <= in_key2;
      r_key3 <= in_key3;
    end else if (r_state == CAPT && !w_final_pass) begin
      r_pass <= r_pass + 2'd1;
    end
  end
`else
  assign w_final_pass = 1'b1;
  assign w_core_key   = r_key;
  assign w_core_dec   = r_dir;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: one RUN sweep per pass, CAPT loops back to RUN for non-final passes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (r_round == LAST_RND) w_state_nxt = CAPT;
      CAPT:    w_state_nxt = w_final_pass ? DONE : RUN;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch request, step the round counter, capture and hold the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round    <= 4'd0;
      r_key      <= '0;
      r_dir      <= 1'b0;
      r_data     <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_blk_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_key   <= in_key;
            r_dir   <= in_decrypt;
            r_data  <= in_data;
            r_round <= 4'd0;
          end
        end
        RUN: begin
          r_round <= (r_round == LAST_RND) ? 4'd0 : r_round + 4'd1;
        end
        CAPT: begin
          if (w_final_pass) begin
            r_out_data <= core_dout;
            r_out_vld  <= 1'b1;
            if (r_blk_cnt != CNT_MAX) r_blk_cnt <= r_blk_cnt + CNT_ONE;
          end else begin
            // Intermediate pass result becomes the next pass's input block.
            r_data <= core_dout;
          end
        end
        DONE: begin
          if (out_ready) r_out_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign out_valid      = r_out_vld;
  assign out_data       = r_out_data;
  assign blk_cnt        = r_blk_cnt;
  assign core_round_sel = (r_state == RUN) ? r_round : 4'd0;
  assign core_key       = w_core_key;
  assign core_decrypt   = w_core_dec;
  assign core_din       = r_data;

endmodule

// File: tb/tb_des_round_seq.sv
// tb_des_round_seq: directed + randomized bench for des_round_seq with a clocked Feistel stand-in core.
// Latency: checks cycle-exact round stepping and result timing.
// Backpressure: exercises out_ready stalls, ignored in_valid while busy, and mid-block reset.
module tb_des_round_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [55:0] in_key;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  core_round_sel;
  logic        core_decrypt;
  logic [55:0] core_key;
  logic [63:0] core_din;
  logic [63:0] core_dout;
  logic        busy;
  logic [15:0] blk_cnt;
`ifdef DES_ROUND_SEQ_TDES_EN
  logic        in_tdes;
  logic [55:0] in_key2;
  logic [55:0] in_key3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  des_round_seq #(.ROUNDS(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
    .in_key(in_key), .in_data(in_data),
`ifdef DES_ROUND_SEQ_TDES_EN
    .in_tdes(in_tdes), .in_key2(in_key2), .in_key3(in_key3),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_round_sel(core_round_sel), .core_decrypt(core_decrypt),
    .core_key(core_key), .core_din(core_din), .core_dout(core_dout),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  // Round-key schedule and round function of the stand-in cipher.
  function automatic logic [31:0] subkey(input logic [55:0] k, input int i);
    logic [55:0] r;
    r = (k << i) | (k >> (56 - i));
    return r[55:24] ^ r[31:0] ^ 32'(32'h9E3779B9 * (i + 1));
  endfunction

  function automatic logic [31:0] ffun(input logic [31:0] r, input logic [31:0] sk);
    logic [31:0] t;
    t = r ^ sk;
    return ({t[26:0], t[31:27]} + 32'(t * 32'h01000193)) ^ {t[15:0], t[31:16]};
  endfunction

  function automatic logic [63:0] fround(input logic [63:0] s, input logic [31:0] sk);
    return {s[31:0], s[63:32] ^ ffun(s[31:0], sk)};
  endfunction

  // Whole-block reference: 16 Feistel rounds, reversed key order for decrypt, final half swap.
  function automatic logic [63:0] des_ref(input logic [63:0] d, input logic [55:0] k, input logic dec);
    logic [63:0] s;
    s = d;
    for (int i = 0; i < 16; i++) s = fround(s, subkey(k, dec ? 15 - i : i));
    return {s[31:0], s[63:32]};
  endfunction

  // Stand-in core: loads desIn when roundSel=0, one round per clock, desOut is the swapped state.
  logic [63:0] core_state;
  always @(posedge clk)
    core_state <= fround((core_round_sel == 4'd0) ? core_din : core_state,
                         subkey(core_key, core_decrypt ? 15 - int'(core_round_sel) : int'(core_round_sel)));
  assign core_dout = {core_state[31:0], core_state[63:32]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full block: accept, 16 checked rounds, timed result, optional out_ready stall, handshake.
  task automatic run_block(input logic [63:0] d, input logic [55:0] k, input logic dec,
                           input bit scr, input int hold, output logic [63:0] res);
    logic [63:0] exp;
    logic [63:0] r64;
    int w;
    exp = des_ref(d, k, dec);
    in_data = d; in_key = k; in_decrypt = dec; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int r = 0; r < 16; r++) begin
      chk("round_sel", core_round_sel, 64'(r));
      chk("core_key", core_key, k);
      chk("core_din", core_din, d);
      chk("core_dec", core_decrypt, dec);
      chk("busy_ready_run", {busy, in_ready}, 2'b10);
      if (scr) begin
        r64 = {$urandom(), $urandom()};
        in_key = r64[55:0]; in_data = ~r64; in_decrypt = r64[3];
      end
      tick();
    end
    chk("capt_quiet", {out_valid, core_round_sel}, 0);
    tick();
    chk("out_valid", out_valid, 1);
    chk("out_data", out_data, exp);
    res = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_ready", {in_ready, core_round_sel}, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_handshake", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] r64;
    logic [55:0] k;
    int n;
    rst = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;
`ifdef DES_ROUND_SEQ_TDES_EN
    in_tdes = 1'b0; in_key2 = '0; in_key3 = '0;
`endif
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_round_sel", core_round_sel, 0);

    // Known block, then its decryption back to plaintext with a long output stall.
    run_block(64'h0123456789ABCDEF, 56'h0, 1'b0, 1'b0, 0, res);
    chk("blk_cnt_1", blk_cnt, 1);
    run_block(res, 56'h0, 1'b1, 1'b0, 20, res);
    chk("roundtrip", res, 64'h0123456789ABCDEF);
    chk("blk_cnt_2", blk_cnt, 2);

    // Random blocks with inputs scrambled during RUN.
    n = 2;
    for (int b = 0; b < 4; b++) begin
      r64 = {$urandom(), $urandom()};
      k = r64[55:0] ^ 56'($urandom());
      run_block({$urandom(), $urandom()}, k, 1'($urandom_range(0, 1)), 1'b1,
                $urandom_range(0, 3), res);
      n++;
      chk("blk_cnt_rand", blk_cnt, 64'(n));
    end

    // Reset in the middle of RUN discards the block and clears the counter.
    in_data = 64'hDEADBEEFCAFEF00D; in_key = 56'h13579BDF02468A; in_decrypt = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("abort_round7", core_round_sel, 7);
    rst = 1'b0;
    #1;
    chk("abort_state", {out_valid, busy, in_ready, core_round_sel}, 7'b0010000);
    chk("abort_blk_cnt", blk_cnt, 0);
    tick();
    rst = 1'b1;
    repeat (20) begin
      tick();
      chk("abort_no_valid", {out_valid, busy}, 0);
    end
    r64 = {$urandom(), $urandom()};
    run_block(r64, r64[63:8], 1'b0, 1'b0, 1, res);
    chk("after_abort_cnt", blk_cnt, 1);

`ifdef DES_ROUND_SEQ_TDES_EN
    // Triple-DES with equal keys reduces to a single encryption; latency 51 cycles.
    r64 = {$urandom(), $urandom()};
    k = r64[55:0];
    in_data = ~r64; in_key = k; in_key2 = k; in_key3 = k; in_decrypt = 1'b0; in_tdes = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_tdes = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("tdes_latency", 64'(n), 51);
    chk("tdes_data", out_data, des_ref(~r64, k, 1'b0));
    chk("tdes_blk_cnt", blk_cnt, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
